// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the clock divider blocks.
package clk_div_pkg;

  localparam int DIV_DEFAULT = 3;

  // Counter width for a mod-n counter; never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/clk_div_counter.sv
// Mod-DIV wrap counter. Reset parks it at DIV-1 so the first released
// edge lands on count 0. Exposes the next-count value so the phase
// register can be driven without an extra cycle of latency.
module clk_div_counter
  import clk_div_pkg::*;
#(
  parameter int DIV   = DIV_DEFAULT,
  parameter int CNT_W = clog2_min1(DIV)
) (
  input  logic             clk,
  input  logic             reset,
  output logic [CNT_W-1:0] cnt_next
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Next count: park at the last value in reset, otherwise wrap DIV-1 -> 0.
  always_comb begin
    cnt_next = cnt + 1'b1;
    if (!reset) begin
      cnt_next = CNT_LAST;
    end else if (cnt == CNT_LAST) begin
      cnt_next = '0;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    cnt <= cnt_next;
  end

endmodule

// File: rtl/div_three_clk.sv
// Clock divider: clk_out runs at clk/DIV with 50% duty. Odd ratios get
// the extra half period from a falling-edge copy of the phase register
// ORed onto the rising-edge phase register.
module div_three_clk
  import clk_div_pkg::*;
#(
  parameter int DIV = DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  output logic clk_out
);

  localparam int              CNT_W = clog2_min1(DIV);
  localparam bit              ODD   = (DIV % 2) == 1;
  localparam logic [CNT_W-1:0] H_EFF = CNT_W'(DIV / 2);

  if (DIV < 2 || DIV > 256) begin : g_bad_div
    $error("div_three_clk: DIV=%0d outside legal range 2..256", DIV);
  end

  logic [CNT_W-1:0] cnt_next;
  logic             p_q;
  logic             n_q;

  clk_div_counter #(
    .DIV   (DIV),
    .CNT_W (CNT_W)
  ) u_counter (
    .clk      (clk),
    .reset    (reset),
    .cnt_next (cnt_next)
  );

  // Rising-edge phase: high for the first H_EFF counts of each period.
  always_ff @(posedge clk) begin
    if (!reset) begin
      p_q <= 1'b0;
    end else begin
      p_q <= (cnt_next < H_EFF);
    end
  end

  // Falling-edge copy of the phase, stretching the high time by half a cycle.
  always_ff @(negedge clk) begin
    if (!reset) begin
      n_q <= 1'b0;
    end else begin
      n_q <= p_q;
    end
  end

  // Registered-only OR, so the output cannot glitch.
  assign clk_out = ODD ? (p_q | n_q) : p_q;

endmodule

// File: tb/tb_div_three_clk.sv
// Bench for div_three_clk: four builds (DIV=2,3,4,5) share one clock and
// one reset. The reference counts clock half-periods since the first
// released rising edge; clk_out must be high for the first DIV half-periods
// of every 2*DIV half-period window, and low once reset has been seen.
module tb_div_three_clk;

  localparam int DIVS [4] = '{2, 3, 4, 5};

  logic       clk;
  logic       reset;
  logic [3:0] co;

  int checks = 0;
  int errors = 0;

  // reference state
  bit running = 1'b0;
  int h       = 0;    // half-periods since first released rising edge
  int age     = -1;   // edges since reset was sampled low (while not running)

  div_three_clk #(.DIV(2)) u_div2 (.clk(clk), .reset(reset), .clk_out(co[0]));
  div_three_clk #(.DIV(3)) u_div3 (.clk(clk), .reset(reset), .clk_out(co[1]));
  div_three_clk #(.DIV(4)) u_div4 (.clk(clk), .reset(reset), .clk_out(co[2]));
  div_three_clk #(.DIV(5)) u_div5 (.clk(clk), .reset(reset), .clk_out(co[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_rise();
    if (!reset) begin
      if (running) begin
        running = 1'b0;
        age     = 0;
      end else begin
        age++;
      end
    end else if (running) begin
      h++;
    end else begin
      running = 1'b1;
      h       = 0;
    end
  endtask

  task automatic model_fall();
    if (running) h++;
    else if (age >= 0) age++;
  endtask

  task automatic check_all(input string ph);
    for (int i = 0; i < 4; i++) begin
      if (running) begin
        chk($sformatf("div%0d_%s_run", DIVS[i], ph), int'(co[i]),
            ((h % (2 * DIVS[i])) < DIVS[i]) ? 1 : 0);
      end else if (age >= 1) begin
        chk($sformatf("div%0d_%s_rst", DIVS[i], ph), int'(co[i]), 0);
      end
    end
  endtask

  // Called just after a rising-edge check; reset changes away from edges.
  task automatic run_cycle(input logic r);
    reset = r;
    @(negedge clk);
    model_fall();
    #1 check_all("fall");
    @(posedge clk);
    model_rise();
    #1 check_all("rise");
  endtask

  initial begin
    int hold_left;
    logic r;
    reset = 1'b0;
    @(posedge clk);
    model_rise();
    #1 check_all("rise");

    // reset held for two cycles, then a long clean run
    run_cycle(1'b0);
    run_cycle(1'b0);
    chk("div3_cnt_in_reset", int'(u_div3.u_counter.cnt), 2);
    for (int i = 0; i < 40; i++) run_cycle(1'b1);

    // mid-run reset, held, counter parked
    for (int i = 0; i < 4; i++) run_cycle(1'b0);
    chk("div3_cnt_held", int'(u_div3.u_counter.cnt), 2);
    chk("div5_cnt_held", int'(u_div5.u_counter.cnt), 4);

    // restart, then single-cycle reset pulse shortly after a DIV=3 rise
    for (int i = 0; i < 7; i++) run_cycle(1'b1);
    run_cycle(1'b0);
    for (int i = 0; i < 12; i++) run_cycle(1'b1);

    // random reset pulses of 1..4 cycles
    hold_left = 0;
    for (int i = 0; i < 500; i++) begin
      if (hold_left > 0) begin
        r = 1'b0;
        hold_left--;
      end else if ($urandom_range(0, 19) == 0) begin
        r = 1'b0;
        hold_left = int'($urandom_range(0, 3));
      end else begin
        r = 1'b1;
      end
      run_cycle(r);
    end

    // long hold low: output must stay at 0
    for (int i = 0; i < 10; i++) run_cycle(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_three_clk.md
Name: div_three_clk

Overview:
- Synchronous clock divider producing `clk_out` at the input clock frequency divided by DIV (default 3) with 50% duty cycle.
- Odd ratios use a rising-edge phase register ORed with a falling-edge copy, giving a half-period extension.
- Used as a local low-rate clock or strobe source from the system clock.

Parameters:
- DIV, 3, division ratio; legal range 2..256; elaboration error outside that range.
- CNT_W, $clog2(DIV), counter width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on its rising edge, except the half-cycle phase register, which updates on its falling edge.
- reset  input  1  synchronous, active-low reset (0 = reset), sampled on clk edges.
- clk_out  output  1  divided clock, period DIV × T(clk), high for DIV/2 × T(clk).

Behaviour:
- Definitions: H = DIV/2 rounded down; ODD = DIV[0].
- Counter `cnt` (CNT_W bits):
  - On rising edge with reset==0: `cnt` <= DIV-1.
  - Otherwise `cnt` <= (`cnt`==DIV-1) ? 0 : `cnt`+1, so it wraps DIV-1 -> 0.
- Phase register `p_q`:
  - On rising edge with reset==0: `p_q` <= 0.
  - Otherwise `p_q` <= (`cnt_next` < H_eff), where H_eff = H for ODD and DIV/2 for even.
- Half-cycle register `n_q`:
  - On falling edge of clk with reset==0: `n_q` <= 0.
  - Otherwise `n_q` <= `p_q`.
- Output: `clk_out` = ODD ? (`p_q` | `n_q`) : `p_q`. This is a glitch-free OR of two registers; no combinational path from reset.
- Reset value: `clk_out` = 0 no later than one full clk period after reset is sampled low. `cnt` = DIV-1, `p_q` = 0, `n_q` = 0.
- First rising edge of clk with reset==1:
  - `cnt` -> 0, `p_q` -> 1, so `clk_out` rises at that edge (one-register latency).
- DIV=3 waveform, per period of 3 clk cycles:
  - `clk_out` high from rising edge k to the falling edge of cycle k+1.
  - Low until rising edge k+3.
  - Result: 30 ns period, 15 ns high at a 10 ns clk.
- Even DIV: `clk_out` high exactly DIV/2 clk periods, low DIV/2 periods; `n_q` is unused.
- Reset mid-operation: any phase is abandoned at the next sampled edge, `clk_out` returns to 0, and the sequence restarts from the first-edge rule when reset returns high. No partial-period state survives.
- Reset held low continuously: `clk_out` stays 0 indefinitely.
- DIV=2 degenerates to a toggle flop with 50% duty.

Decomposition:
- Shared package (clk_div_pkg): function `clog2_min1` returning max(1,$clog2(n)), and constant DIV_DEFAULT = 3.
- One natural sub-module: `clk_div_counter` (mod-DIV wrap counter with synchronous active-low reset, `cnt_next` output).
- Phase registers and output OR remain in the top.

Test Plan:
- Reset then run, DIV=3, clk 10 ns: hold reset=0 for 2 cycles, then release -> `clk_out` rises at the first rising edge after release. Period 30 ns, high 15 ns, low 15 ns, for 10 consecutive periods.
- Reset assertion check: drive reset=0 during run -> `clk_out`=0 within one clk period, stays 0 while reset=0, `cnt`=2.
- Reset mid-high-phase: assert reset 5 ns after a `clk_out` rising edge for 1 cycle -> `clk_out` falls by the next falling/rising edge. Restart phase aligns to the first rising edge after release.
- DIV=4 build: release reset -> `clk_out` period 40 ns, high exactly 20 ns, edges aligned to clk rising edges only.
- DIV=5 build: `clk_out` period 50 ns, high 25 ns; falling edge of `clk_out` coincides with a clk falling edge.
- DIV=2 build: `clk_out` toggles every rising edge after release, period 20 ns, 50% duty.
